vx_writeback: RTL and testbench

Commit-side arbiter that merges the per-unit commit streams (ALU, LSU, CSR, FPU, GPU) into the single registered writeback stream. The issue stage's GPR file and scoreboard consume that stream. It sits between the execute units and the issue stage. It retires non-writing commits without using the port and counts retired instructions for perf.

---
 rtl/vx_writeback_pkg.sv | 36 +++
 rtl/vx_writeback_rr_arbiter.sv | 30 +++
 rtl/vx_writeback.sv | 94 +++++++++
 tb/tb_vx_writeback.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vx_writeback_pkg.sv
// vx_writeback_pkg: shared commit/writeback packet types and source indices for the writeback merge
package vx_writeback_pkg;
  localparam int NUM_REQS    = 5;
  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int WID_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NR_BITS     = 6;
  localparam int UUID_BITS   = 44;
  localparam int EX_ALU = 0;
  localparam int EX_LSU = 1;
  localparam int EX_CSR = 2;
  localparam int EX_FPU = 3;
  localparam int EX_GPU = 4;
  typedef struct packed {
    logic [UUID_BITS-1:0]             uuid;
    logic [WID_BITS-1:0]              wid;
    logic [31:0]                      pc;
    logic [NUM_THREADS-1:0]           tmask;
    logic                             wb;
    logic [NR_BITS-1:0]               rd;
    logic [NUM_THREADS-1:0][31:0]     data;
    logic                             eop;
  } cmt_pkt_t;
  typedef struct packed {
    logic [UUID_BITS-1:0]             uuid;
    logic [WID_BITS-1:0]              wid;
    logic [31:0]                      pc;
    logic [NUM_THREADS-1:0]           tmask;
    logic [NR_BITS-1:0]               rd;
    logic [NUM_THREADS-1:0][31:0]     data;
    logic                             eop;
  } wb_pkt_t;
  function automatic wb_pkt_t to_wb(input cmt_pkt_t c);
    to_wb = '{uuid: c.uuid, wid: c.wid, pc: c.pc, tmask: c.tmask, rd: c.rd, data: c.data, eop: c.eop};
  endfunction
endpackage

// File: rtl/vx_writeback_rr_arbiter.sv
// vx_rr_arbiter: one-hot round-robin grant; priority starts at a pointer that moves past each winner
module vx_rr_arbiter #(
  parameter int NUM_REQS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  output logic [NUM_REQS-1:0] grant
);
  localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  logic [PW-1:0] r_ptr, w_nxt, w_j;
  // scan from farthest to nearest so the source closest to the pointer wins last
  always_comb begin
    grant = '0;
    w_nxt = r_ptr;
    w_j   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      w_j = PW'((int'(r_ptr) + k) % NUM_REQS);
      if (req[w_j]) begin
        grant      = '0;
        grant[w_j] = 1'b1;
        w_nxt      = (int'(w_j) == NUM_REQS - 1) ? '0 : w_j + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) r_ptr <= '0;
    else if (|grant) r_ptr <= w_nxt;
  end
endmodule

// File: rtl/vx_writeback.sv
// vx_writeback: merges per-unit commit streams into one registered writeback port
// and counts retired instructions.
module vx_writeback import vx_writeback_pkg::*; #(
  parameter int CORE_ID     = 0,
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44,
  parameter int WID_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQS-1:0]                     cmt_valid,
  output logic [NUM_REQS-1:0]                     cmt_ready,
  input  logic [NUM_REQS-1:0][UUID_BITS-1:0]      cmt_uuid,
  input  logic [NUM_REQS-1:0][WID_BITS-1:0]       cmt_wid,
  input  logic [NUM_REQS-1:0][31:0]               cmt_PC,
  input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]    cmt_tmask,
  input  logic [NUM_REQS-1:0]                     cmt_wb,
  input  logic [NUM_REQS-1:0][NR_BITS-1:0]        cmt_rd,
  input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] cmt_data,
  input  logic [NUM_REQS-1:0]                     cmt_eop,
  output logic                                    wb_valid,
  output logic [UUID_BITS-1:0]                    wb_uuid,
  output logic [WID_BITS-1:0]                     wb_wid,
  output logic [31:0]                             wb_PC,
  output logic [NUM_THREADS-1:0]                  wb_tmask,
  output logic [NR_BITS-1:0]                      wb_rd,
  output logic [NUM_THREADS-1:0][31:0]            wb_data,
  output logic                                    wb_eop,
  output logic [63:0]                             perf_instret
);
  // packet structs are sized by the package, so the parameters must agree with it
  if (NUM_REQS != vx_writeback_pkg::NUM_REQS || NUM_THREADS != vx_writeback_pkg::NUM_THREADS ||
      WID_BITS != vx_writeback_pkg::WID_BITS || NR_BITS != vx_writeback_pkg::NR_BITS ||
      UUID_BITS != vx_writeback_pkg::UUID_BITS || CORE_ID < 0) begin : g_cfg_err
    $error("vx_writeback parameters disagree with vx_writeback_pkg");
  end
  cmt_pkt_t [NUM_REQS-1:0] w_cmt;
  wb_pkt_t             w_mux, r_wb;
  logic [NUM_REQS-1:0] w_val, w_wr, w_gnt, w_fire;
  logic                r_valid;
  logic [63:0]         r_instret;
  function automatic logic [63:0] popcount(input logic [NUM_REQS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_REQS; i++) popcount += 64'(v[i]);
  endfunction
  always_comb begin
    w_cmt = '0;
    w_val = '0;
    w_wr  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_cmt[i] = '{uuid: cmt_uuid[i], wid: cmt_wid[i], pc: cmt_PC[i], tmask: cmt_tmask[i],
                   wb: cmt_wb[i], rd: cmt_rd[i], data: cmt_data[i], eop: cmt_eop[i]};
      w_val[i] = cmt_valid[i] && !reset;
      w_wr[i]  = w_val[i] && w_cmt[i].wb && w_cmt[i].rd != '0;
    end
  end
  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (w_wr),
    .grant(w_gnt)
  );
  always_comb begin
    w_mux = '0;
    for (int i = 0; i < NUM_REQS; i++)
      w_mux = wb_pkt_t'(w_mux | ({$bits(wb_pkt_t){w_gnt[i]}} & to_wb(w_cmt[i])));
  end
  // non-writing commits retire immediately; writers only on their grant
  assign cmt_ready = (w_val & ~w_wr) | w_gnt;
  assign w_fire    = cmt_valid & cmt_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_wb      <= '0;
      r_instret <= '0;
    end else begin
      r_valid   <= |w_gnt;
      if (|w_gnt) r_wb <= w_mux;
      r_instret <= r_instret + popcount(w_fire & cmt_eop);
    end
  end
  assign wb_valid     = r_valid;
  assign wb_uuid      = r_wb.uuid;
  assign wb_wid       = r_wb.wid;
  assign wb_PC        = r_wb.pc;
  assign wb_tmask     = r_wb.tmask;
  assign wb_rd        = r_wb.rd;
  assign wb_data      = r_wb.data;
  assign wb_eop       = r_wb.eop;
  assign perf_instret = r_instret;
endmodule

// File: tb/tb_vx_writeback.sv
// tb_vx_writeback: directed and random commit traffic checked against a queue-free behavioural model
module tb_vx_writeback;
  localparam int N = 5;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] cmt_valid, cmt_ready, cmt_wb, cmt_eop;
  logic [N-1:0][43:0] cmt_uuid;
  logic [N-1:0][1:0] cmt_wid;
  logic [N-1:0][31:0] cmt_PC;
  logic [N-1:0][3:0] cmt_tmask;
  logic [N-1:0][5:0] cmt_rd;
  logic [N-1:0][3:0][31:0] cmt_data;
  logic wb_valid, wb_eop;
  logic [43:0] wb_uuid;
  logic [1:0] wb_wid;
  logic [31:0] wb_PC;
  logic [3:0] wb_tmask;
  logic [5:0] wb_rd;
  logic [3:0][31:0] wb_data;
  logic [63:0] perf_instret;
  int n_chk = 0, n_fail = 0;
  int ptr = 0, last_w = -1;
  logic [N-1:0] last_rdy;
  logic m_valid = 1'b0;
  logic [216:0] m_pay = '0;
  logic [63:0] m_ret = '0;

  vx_writeback dut (
    .clk(clk), .reset(reset), .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_uuid(cmt_uuid),
    .cmt_wid(cmt_wid), .cmt_PC(cmt_PC), .cmt_tmask(cmt_tmask), .cmt_wb(cmt_wb), .cmt_rd(cmt_rd),
    .cmt_data(cmt_data), .cmt_eop(cmt_eop), .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
    .wb_PC(wb_PC), .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .perf_instret(perf_instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear();
    cmt_valid = '0; cmt_wb = '0; cmt_eop = '0; cmt_uuid = '0; cmt_wid = '0;
    cmt_PC = '0; cmt_tmask = '0; cmt_rd = '0; cmt_data = '0;
  endtask

  task automatic set_src(input int i, input logic [43:0] u, input logic w, input logic [5:0] rd, input logic e);
    cmt_valid[i] = 1'b1; cmt_uuid[i] = u; cmt_wb[i] = w; cmt_rd[i] = rd; cmt_eop[i] = e;
    cmt_wid[i] = 2'($urandom); cmt_PC[i] = $urandom; cmt_tmask[i] = 4'($urandom);
    for (int t = 0; t < 4; t++) cmt_data[i][t] = $urandom;
  endtask

  // one clock: check combinational ready, advance the model, then check registered outputs
  task automatic step();
    logic [N-1:0] rdy;
    int w;
    #1;
    rdy = '0;
    w = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (w < 0 && cmt_valid[j] && cmt_wb[j] && cmt_rd[j] != 0) w = j;
      end
      for (int i = 0; i < N; i++)
        if (cmt_valid[i] && !(cmt_wb[i] && cmt_rd[i] != 0)) rdy[i] = 1'b1;
      if (w >= 0) rdy[w] = 1'b1;
    end
    chk("cmt_ready", 256'(cmt_ready), 256'(rdy));
    last_rdy = cmt_ready;
    last_w = w;
    if (reset) begin
      m_valid = 1'b0; m_pay = '0; m_ret = '0; ptr = 0;
    end else begin
      m_ret += 64'($countones(rdy & cmt_eop));
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_pay = {cmt_uuid[w], cmt_wid[w], cmt_PC[w], cmt_tmask[w], cmt_rd[w], cmt_data[w], cmt_eop[w]};
        ptr = (w + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_valid", 256'(wb_valid), 256'(m_valid));
    chk("wb_payload", 256'({wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_eop}), 256'(m_pay));
    chk("perf_instret", 256'(perf_instret), 256'(m_ret));
  endtask

  initial begin
    int lsu_n, alu_n;
    logic [63:0] base;
    logic [43:0] q[$];
    clear();
    @(negedge clk);
    // commits offered during reset must be ignored
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) set_src(i, 44'(i), 1'b1, 6'(i + 1), 1'b1);
      step();
      chk("reset_ready", 256'(last_rdy), 256'(0));
    end
    clear();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("idle_valid", 256'(wb_valid), 256'(0));
    chk("idle_instret", 256'(perf_instret), 256'(0));

    set_src(0, 44'h77, 1'b1, 6'd5, 1'b1);
    cmt_wid[0] = 2'd2;
    for (int t = 0; t < 4; t++) cmt_data[0][t] = 32'h1234;
    step();
    chk("alu_ready", 256'(last_rdy), 256'(5'b00001));
    chk("alu_valid", 256'(wb_valid), 256'(1));
    chk("alu_rd", 256'(wb_rd), 256'(5));
    chk("alu_wid", 256'(wb_wid), 256'(2));
    chk("alu_data", 256'(wb_data), 256'({4{32'h1234}}));
    chk("alu_instret", 256'(perf_instret), 256'(1));
    clear();

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 44'(i), 1'b1, 6'(i + 1), 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("rr_order", 256'(wb_uuid), 256'(c % N));
      chk("rr_valid", 256'(wb_valid), 256'(1));
    end
    chk("rr_instret", 256'(perf_instret), 256'(10));

    clear();
    set_src(2, 44'h20, 1'b0, 6'd9, 1'b1);
    set_src(3, 44'h30, 1'b1, 6'd7, 1'b1);
    set_src(4, 44'h40, 1'b1, 6'd0, 1'b1);
    step();
    chk("mix_ready", 256'(last_rdy), 256'(5'b11100));
    chk("mix_rd", 256'(wb_rd), 256'(7));
    chk("mix_uuid", 256'(wb_uuid), 256'(44'h30));
    chk("mix_instret", 256'(perf_instret), 256'(13));

    clear();
    base = m_ret;
    lsu_n = 0;
    alu_n = 0;
    set_src(0, 44'd100, 1'b1, 6'd3, 1'b1);
    set_src(1, 44'd200, 1'b1, 6'd4, 1'b0);
    for (int t = 0; t < 20 && lsu_n < 3; t++) begin
      step();
      if (wb_valid && wb_uuid >= 44'd200 && wb_uuid < 44'd203) q.push_back(wb_uuid);
      if (last_rdy[1]) begin
        lsu_n++;
        if (lsu_n < 3) set_src(1, 44'(200 + lsu_n), 1'b1, 6'd4, lsu_n == 2);
        else cmt_valid[1] = 1'b0;
      end
      if (last_rdy[0]) begin
        alu_n++;
        set_src(0, 44'(100 + alu_n), 1'b1, 6'd3, 1'b1);
      end
    end
    chk("lsu_count", 256'(q.size()), 256'(3));
    chk("lsu_order", 256'({q[0], q[1], q[2]}), 256'({44'd200, 44'd201, 44'd202}));
    chk("lsu_instret", 256'(perf_instret - base), 256'(alu_n + 1));

    clear();
    set_src(1, 44'h11, 1'b1, 6'd1, 1'b1);
    step();
    clear();
    reset = 1'b1;
    step();
    chk("rst_drop", 256'(wb_valid), 256'(0));
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 44'(i), 1'b1, 6'(i + 1), 1'b1);
    step();
    chk("rst_ptr", 256'(wb_uuid), 256'(0));

    for (int c = 0; c < 2000; c++) begin
      clear();
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1)
          set_src(i, {12'($urandom), $urandom}, 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom), 1'($urandom));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
